// File: rtl/buf_fifo_sync.sv
// buf_fifo_sync: synchronous first-word-fall-through elastic buffer.
// Valid/ready on both sides; outputs decoded from registered state only.
module buf_fifo_sync #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WIDTH-1:0]           I,
  input  logic                       I_VALID,
  output logic                       I_READY,
  output logic [WIDTH-1:0]           Z,
  output logic                       Z_VALID,
  input  logic                       Z_READY,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       AFULL,
  inout  logic                       VDD,
  inout  logic                       VSS
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  // Supply pins carry no logic function in this cell.
  logic unused_pwr;
  assign unused_pwr = VDD ^ VSS;

  // Flags and head data decoded purely from registers.
  always_comb begin
    I_READY = 1'b0;
    Z_VALID = 1'b0;
    AFULL   = 1'b0;
    Z       = '0;
    COUNT   = count;
    I_READY = (count != FULL_CNT);
    Z_VALID = (count != '0);
    AFULL   = (count >= AFULL_CNT);
    if (Z_VALID) begin
      Z = mem[rd_ptr];
    end
  end

  // Handshake qualification.
  always_comb begin
    push = I_VALID & I_READY;
    pop  = Z_VALID & Z_READY;
  end

  // Pointers and occupancy; reset wins over any transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; array contents are never reset.
  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      mem[wr_ptr] <= I;
    end
  end

endmodule

// File: tb/tb_buf_fifo_sync.sv
// tb_buf_fifo_sync: directed vectors on the default build,
// plus a queue-model run on an 8-deep 13-bit build.
module tb_buf_fifo_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  wire vdd = 1'b1;
  wire vss = 1'b0;

  logic       rst;
  logic [7:0] a_i;
  logic       a_iv;
  logic       a_ir;
  logic [7:0] a_z;
  logic       a_zv;
  logic       a_zr;
  logic [2:0] a_cnt;
  logic       a_af;

  logic [12:0] b_i;
  logic        b_iv;
  logic        b_ir;
  logic [12:0] b_z;
  logic        b_zv;
  logic        b_zr;
  logic [3:0]  b_cnt;
  logic        b_af;

  int checks = 0;
  int errors = 0;

  buf_fifo_sync #(.WIDTH(8), .DEPTH(4), .AFULL_LVL(3)) u_a (
    .CLK(clk), .RST(rst),
    .I(a_i), .I_VALID(a_iv), .I_READY(a_ir),
    .Z(a_z), .Z_VALID(a_zv), .Z_READY(a_zr),
    .COUNT(a_cnt), .AFULL(a_af),
    .VDD(vdd), .VSS(vss)
  );

  buf_fifo_sync #(.WIDTH(13), .DEPTH(8), .AFULL_LVL(8)) u_b (
    .CLK(clk), .RST(rst),
    .I(b_i), .I_VALID(b_iv), .I_READY(b_ir),
    .Z(b_z), .Z_VALID(b_zv), .Z_READY(b_zr),
    .COUNT(b_cnt), .AFULL(b_af),
    .VDD(vdd), .VSS(vss)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int cnt,
                       input logic [7:0] z);
    chk({tag, ".count"}, 32'(a_cnt), 32'(cnt));
    chk({tag, ".zvalid"}, 32'(a_zv), 32'(cnt != 0));
    chk({tag, ".z"}, 32'(a_z), (cnt != 0) ? 32'(z) : 32'h0);
    chk({tag, ".iready"}, 32'(a_ir), 32'(cnt != 4));
    chk({tag, ".afull"}, 32'(a_af), 32'(cnt >= 3));
  endtask

  logic [12:0] q[$];
  logic [7:0]  pv[4];

  initial begin
    rst = 1'b1;
    a_i = '0; a_iv = 0; a_zr = 0;
    b_i = '0; b_iv = 0; b_zr = 0;
    pv[0] = 8'h11; pv[1] = 8'h22;
    pv[2] = 8'h33; pv[3] = 8'h44;
    #1;

    // 1: reset then idle, pops on empty ignored
    step();
    rst = 1'b0;
    chk_a("rst", 0, 8'h00);
    a_zr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_a("empty_pop", 0, 8'h00);
    end

    // 2: fill to full, head stays 0x11
    a_zr = 1'b0;
    a_iv = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_i = pv[k];
      step();
      chk_a("fill", k + 1, 8'h11);
    end

    // 3: push while full ignored, then drain in order
    a_i  = 8'h55;
    a_zr = 1'b1;
    step();
    chk_a("full_pop", 3, 8'h22);
    a_iv = 1'b0;
    step();
    chk_a("drain1", 2, 8'h33);
    step();
    chk_a("drain2", 1, 8'h44);
    step();
    chk_a("drain3", 0, 8'h00);

    // 4: streaming push/pop at occupancy 1
    a_zr = 1'b0;
    a_iv = 1'b1;
    a_i  = 8'h00;
    step();
    chk_a("stream0", 1, 8'h00);
    a_zr = 1'b1;
    for (int k = 1; k < 256; k++) begin
      a_i = 8'(k);
      step();
      chk_a("stream", 1, 8'(k));
    end
    a_iv = 1'b0;
    step();
    chk_a("stream_end", 0, 8'h00);

    // 5: reset mid-operation discards contents
    a_zr = 1'b0;
    a_iv = 1'b1;
    a_i  = 8'h66;
    step();
    a_i  = 8'h77;
    step();
    chk_a("pre_rst", 2, 8'h66);
    rst  = 1'b1;
    a_zr = 1'b1;
    a_i  = 8'h88;
    step();
    chk_a("mid_rst", 0, 8'h00);
    rst  = 1'b0;
    a_zr = 1'b0;
    a_i  = 8'hA5;
    step();
    chk_a("post_rst", 1, 8'hA5);
    a_iv = 1'b0;

    // 6: random traffic against a queue model
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      chk("rnd.count", 32'(b_cnt), 32'(q.size()));
      chk("rnd.zvalid", 32'(b_zv), 32'(q.size() != 0));
      chk("rnd.z", 32'(b_z),
          (q.size() != 0) ? 32'(q[0]) : 32'h0);
      chk("rnd.iready", 32'(b_ir), 32'(q.size() != 8));
      chk("rnd.afull", 32'(b_af), 32'(q.size() == 8));
      b_iv = 1'($urandom_range(0, 1));
      b_zr = 1'($urandom_range(0, 1));
      b_i  = 13'($urandom);
      if (b_zr && q.size() != 0) begin
        if (b_iv && q.size() != 8)
          q.push_back(b_i);
        void'(q.pop_front());
      end else if (b_iv && q.size() != 8) begin
        q.push_back(b_i);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
